// File: rtl/player_hit_detector.sv
// player_hit_detector
// Turns per-pixel player/missile overlap into at most one hit pulse per frame.
// The pulse is issued one clock after the startOfFrame that closes the
// colliding frame. After each hit an invulnerability window of INVULN_FRAMES
// frames follows. The player dies after MAX_HITS accepted hits.
//
// Handshake: there is no valid/ready pair. startOfFrame, game_restart and
// got_hit/missile_destroy are single-cycle strobes that are qualified only by
// being high on a rising clk edge.
module player_hit_detector #(
    parameter int INVULN_FRAMES = 60,  // 1..255
    parameter int MAX_HITS      = 4    // 1..7
) (
    input  logic       clk,
    input  logic       resetN,          // asynchronous, active-high
    input  logic       startOfFrame,
    input  logic       playerDrawingRequest,
    input  logic       missileDrawingRequest,
    input  logic       game_restart,
    output logic       got_hit,
    output logic       missile_destroy,
    output logic       invulnerable,
    output logic [2:0] hits_taken,
    output logic       player_dead
);

    typedef enum logic [1:0] {
        ARMED_ST    = 2'd0,
        COOLDOWN_ST = 2'd1,
        DEAD_ST     = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       collision_flag, collision_flag_nxt;
    logic [7:0] cooldown_cnt, cooldown_cnt_nxt;
    logic [2:0] hits_nxt;
    logic       hit_nxt;
    logic       overlap;
    logic       collision_eval;

    // Overlap seen on the startOfFrame cycle itself still belongs to the
    // frame that is ending, so it is ORed into the evaluated value.
    assign overlap        = playerDrawingRequest & missileDrawingRequest;
    assign collision_eval = collision_flag | overlap;

    // Next-state logic: frame evaluation, cooldown countdown, restart override.
    always_comb begin
        state_nxt          = state;
        collision_flag_nxt = collision_flag;
        cooldown_cnt_nxt   = cooldown_cnt;
        hits_nxt           = hits_taken;
        hit_nxt            = 1'b0;

        case (state)
            ARMED_ST: begin
                if (startOfFrame) begin
                    collision_flag_nxt = 1'b0;
                    if (collision_eval) begin
                        hit_nxt  = 1'b1;
                        hits_nxt = hits_taken + 3'd1;
                        if (hits_taken + 3'd1 == 3'(MAX_HITS)) begin
                            state_nxt        = DEAD_ST;
                            cooldown_cnt_nxt = 8'd0;
                        end else begin
                            state_nxt        = COOLDOWN_ST;
                            cooldown_cnt_nxt = 8'(INVULN_FRAMES);
                        end
                    end
                end else if (overlap) begin
                    collision_flag_nxt = 1'b1;
                end
            end
            COOLDOWN_ST: begin
                collision_flag_nxt = 1'b0;
                if (startOfFrame) begin
                    // A count of 1 means this decrement reaches zero.
                    if (cooldown_cnt <= 8'd1) begin
                        state_nxt        = ARMED_ST;
                        cooldown_cnt_nxt = 8'd0;
                    end else begin
                        cooldown_cnt_nxt = cooldown_cnt - 8'd1;
                    end
                end
            end
            DEAD_ST: begin
                collision_flag_nxt = 1'b0;
            end
            default: begin
                state_nxt          = ARMED_ST;
                collision_flag_nxt = 1'b0;
                cooldown_cnt_nxt   = 8'd0;
            end
        endcase

        // Restart wins over everything, including a hit decided this cycle.
        if (game_restart) begin
            state_nxt          = ARMED_ST;
            collision_flag_nxt = 1'b0;
            cooldown_cnt_nxt   = 8'd0;
            hits_nxt           = 3'd0;
            hit_nxt            = 1'b0;
        end
    end

    // State and registered outputs; outputs are derived from the next state
    // so that they line up with the state they describe.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state           <= ARMED_ST;
            collision_flag  <= 1'b0;
            cooldown_cnt    <= 8'd0;
            hits_taken      <= 3'd0;
            got_hit         <= 1'b0;
            missile_destroy <= 1'b0;
            invulnerable    <= 1'b0;
            player_dead     <= 1'b0;
        end else begin
            state           <= state_nxt;
            collision_flag  <= collision_flag_nxt;
            cooldown_cnt    <= cooldown_cnt_nxt;
            hits_taken      <= hits_nxt;
            got_hit         <= hit_nxt;
            missile_destroy <= hit_nxt;
            invulnerable    <= (state_nxt == COOLDOWN_ST);
            player_dead     <= (state_nxt == DEAD_ST);
        end
    end

endmodule

// File: tb/tb_player_hit_detector.sv
// tb_player_hit_detector
// Directed frames with hand-computed expectations for player_hit_detector
// (INVULN_FRAMES=3, MAX_HITS=4).
module tb_player_hit_detector;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       playerDrawingRequest;
    logic       missileDrawingRequest;
    logic       game_restart;
    logic       got_hit;
    logic       missile_destroy;
    logic       invulnerable;
    logic [2:0] hits_taken;
    logic       player_dead;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;

    player_hit_detector #(
        .INVULN_FRAMES(3),
        .MAX_HITS     (4)
    ) u_dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .playerDrawingRequest (playerDrawingRequest),
        .missileDrawingRequest(missileDrawingRequest),
        .game_restart         (game_restart),
        .got_hit              (got_hit),
        .missile_destroy      (missile_destroy),
        .invulnerable         (invulnerable),
        .hits_taken           (hits_taken),
        .player_dead          (player_dead)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // count every rising edge of got_hit, including ones cut short by reset
    always @(posedge got_hit) pulses++;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // len cycles inside a frame; overlap on cycles [ov_lo, ov_hi)
    task automatic body(input int len, input int ov_lo, input int ov_hi,
                        input logic pl);
        for (int i = 0; i < len; i++) begin
            missileDrawingRequest = (i >= ov_lo) && (i < ov_hi);
            playerDrawingRequest  = pl && (i >= ov_lo) && (i < ov_hi);
            step();
            check_eq("quiet_got_hit", got_hit, 0);
            check_eq("quiet_missile_destroy", missile_destroy, 0);
        end
        playerDrawingRequest  = 1'b0;
        missileDrawingRequest = 1'b0;
    endtask

    // one startOfFrame cycle, optional same-cycle overlap and restart
    task automatic do_sof(input logic ov, input logic rs, input logic exp_hit);
        startOfFrame          = 1'b1;
        playerDrawingRequest  = ov;
        missileDrawingRequest = ov;
        game_restart          = rs;
        step();
        startOfFrame          = 1'b0;
        playerDrawingRequest  = 1'b0;
        missileDrawingRequest = 1'b0;
        game_restart          = 1'b0;
        check_eq("sof_got_hit", got_hit, exp_hit);
        check_eq("sof_missile_destroy", missile_destroy, exp_hit);
        if (exp_hit) exp_pulses++;
    endtask

    // three quiet frames to run out the invulnerability window
    task automatic wait_cooldown();
        for (int f = 0; f < 3; f++) begin
            check_eq("cooldown_invuln", invulnerable, 1);
            body(6, 0, 0, 1'b1);
            do_sof(1'b0, 1'b0, 1'b0);
        end
        check_eq("cooldown_done", invulnerable, 0);
    endtask

    initial begin
        resetN                = 1'b1;
        startOfFrame          = 1'b0;
        playerDrawingRequest  = 1'b0;
        missileDrawingRequest = 1'b0;
        game_restart          = 1'b0;
        #12;
        check_eq("rst_got_hit", got_hit, 0);
        check_eq("rst_missile_destroy", missile_destroy, 0);
        check_eq("rst_invuln", invulnerable, 0);
        check_eq("rst_hits", hits_taken, 0);
        check_eq("rst_dead", player_dead, 0);
        @(posedge clk);
        #1;
        resetN = 1'b0;

        // three frames with no overlap
        for (int f = 0; f < 3; f++) begin
            body(8, 0, 0, 1'b1);
            do_sof(1'b0, 1'b0, 1'b0);
        end
        check_eq("idle_hits", hits_taken, 0);
        check_eq("idle_invuln", invulnerable, 0);

        // five-cycle overlap mid-frame -> one hit at frame close
        body(10, 2, 7, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("hit1_hits", hits_taken, 1);
        check_eq("hit1_invuln", invulnerable, 1);

        // overlaps during the 3 invulnerable frames are ignored,
        // including one on the startOfFrame that ends the window
        body(8, 1, 6, 1'b1);
        do_sof(1'b0, 1'b0, 1'b0);
        body(8, 1, 6, 1'b1);
        do_sof(1'b0, 1'b0, 1'b0);
        body(8, 1, 6, 1'b1);
        do_sof(1'b1, 1'b0, 1'b0);
        check_eq("window_hits", hits_taken, 1);
        check_eq("window_over_invuln", invulnerable, 0);

        // overlap in frame 4 registers
        body(8, 3, 4, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("hit2_hits", hits_taken, 2);
        check_eq("hit2_invuln", invulnerable, 1);

        // restart mid-cooldown with two hits taken
        body(3, 0, 0, 1'b1);
        game_restart = 1'b1;
        step();
        game_restart = 1'b0;
        check_eq("restart_hits", hits_taken, 0);
        check_eq("restart_invuln", invulnerable, 0);
        check_eq("restart_dead", player_dead, 0);
        check_eq("restart_got_hit", got_hit, 0);

        // armed again straight away
        body(6, 2, 3, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("rearm_hits", hits_taken, 1);
        wait_cooldown();

        // overlap only on the startOfFrame cycle counts for the closing frame
        body(6, 0, 0, 1'b1);
        do_sof(1'b1, 1'b0, 1'b1);
        check_eq("samecyc_hits", hits_taken, 2);
        wait_cooldown();

        // missile pixels without player pixels are not a hit
        body(8, 1, 7, 1'b0);
        do_sof(1'b0, 1'b0, 1'b0);
        check_eq("noplayer_hits", hits_taken, 2);

        // hits 3 and 4 -> dead
        body(6, 4, 5, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("hit3_hits", hits_taken, 3);
        wait_cooldown();
        body(6, 4, 5, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("hit4_hits", hits_taken, 4);
        check_eq("hit4_dead", player_dead, 1);
        check_eq("hit4_invuln", invulnerable, 0);

        // dead: further overlap ignored, hits hold at 4
        body(6, 0, 6, 1'b1);
        do_sof(1'b1, 1'b0, 1'b0);
        check_eq("dead_hits", hits_taken, 4);
        check_eq("dead_still", player_dead, 1);

        // restart after death
        game_restart = 1'b1;
        step();
        game_restart = 1'b0;
        check_eq("revive_dead", player_dead, 0);
        check_eq("revive_hits", hits_taken, 0);

        // restart on the same cycle as a hit-producing startOfFrame discards it
        body(6, 1, 3, 1'b1);
        do_sof(1'b0, 1'b1, 1'b0);
        check_eq("discard_hits", hits_taken, 0);
        check_eq("discard_invuln", invulnerable, 0);

        // async reset in the middle of a hit pulse
        body(6, 1, 3, 1'b1);
        do_sof(1'b0, 1'b0, 1'b1);
        check_eq("prereset_hits", hits_taken, 1);
        #2;
        resetN = 1'b1;
        #1;
        check_eq("async_got_hit", got_hit, 0);
        check_eq("async_missile_destroy", missile_destroy, 0);
        check_eq("async_hits", hits_taken, 0);
        check_eq("async_invuln", invulnerable, 0);
        step();
        resetN = 1'b0;
        body(4, 0, 0, 1'b1);

        check_eq("pulse_total", pulses, exp_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
